oled_source_arbiter: RTL and testbench

//  Frame-synchronous arbiter sharing the single 96x64 OLED pixel stream between up to N_SRC

---
 rtl/oled_source_arbiter.sv | 161 ++++++++++++++++
 tb/tb_oled_source_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/oled_source_arbiter.sv
// Frame-synchronous arbiter giving one renderer ownership of the 96x64 OLED pixel stream,
// with blank frames on every hand-over. Optional outline via `BORDER_EN.
module oled_source_arbiter #(
   parameter int unsigned N_SRC          = 4,
   parameter int unsigned BLANK_FRAMES   = 2,
   parameter logic [15:0] DEFAULT_COLOUR = 16'h0000,
   parameter logic [15:0] BORDER_COLOUR  = 16'h07E0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_begin,
   input  logic [N_SRC-1:0]     req,
   input  logic [16*N_SRC-1:0]  src_pixel,
   input  logic [12:0]          pixel_index,
   output logic [15:0]          pixel_data,
   output logic [N_SRC-1:0]     grant,
   output logic                 active,
   output logic                 switching
);

   localparam int unsigned CNT_W     = (BLANK_FRAMES < 2) ? 1 : $clog2(BLANK_FRAMES + 1);
   localparam int unsigned PIX_TOTAL = 6144;
   localparam bit          DIRECT    = (BLANK_FRAMES == 0);

   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_e;

   state_e             state_q, state_d;
   logic [N_SRC-1:0]   grant_q, grant_d;
   logic [N_SRC-1:0]   pending_q, pending_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_SRC-1:0]   req_s1_q, req_s2_q;
   logic               active_q, switching_q;
   logic [15:0]        pix_q, pix_d;
   logic [N_SRC-1:0]   winner_c;
   logic [15:0]        sel_pix_c;

   // Fixed priority: lowest-index synced request wins, one-hot.
   always_comb begin
      winner_c = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req_s2_q[i]) winner_c = N_SRC'(1) << i;
      end
   end

   // Ownership decisions are taken only on frame_begin.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      if (frame_begin) begin
         case (state_q)
            ST_IDLE: begin
               if (|winner_c) begin
                  pending_d = winner_c;
                  if (DIRECT) begin
                     state_d = ST_SHOW;
                     grant_d = winner_c;
                  end else begin
                     state_d = ST_BLANK;
                     cnt_d   = CNT_W'(BLANK_FRAMES);
                  end
               end
            end
            ST_BLANK: begin
               if (!(|winner_c)) begin
                  state_d   = ST_IDLE;
                  pending_d = '0;
               end else if (winner_c != pending_q) begin
                  pending_d = winner_c;
                  cnt_d     = CNT_W'(BLANK_FRAMES);
               end else if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_SHOW;
                  grant_d = pending_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_SHOW: begin
               if (!(|winner_c)) begin
                  state_d   = ST_IDLE;
                  grant_d   = '0;
                  pending_d = '0;
               end else if (winner_c != grant_q) begin
                  pending_d = winner_c;
                  if (DIRECT) begin
                     grant_d = winner_c;
                  end else begin
                     grant_d = '0;
                     state_d = ST_BLANK;
                     cnt_d   = CNT_W'(BLANK_FRAMES);
                  end
               end
            end
            default: begin
               state_d   = ST_IDLE;
               grant_d   = '0;
               pending_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      sel_pix_c = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) sel_pix_c = sel_pix_c | src_pixel[16*i +: 16];
      end
   end

`ifdef BORDER_EN
   logic [6:0] x_c;
   logic       on_border_c;
   always_comb begin
      x_c         = 7'(pixel_index % 13'd96);
      on_border_c = (x_c == 7'd0) || (x_c == 7'd95) ||
                    (pixel_index < 13'd96) || (pixel_index >= 13'd6048);
   end
`endif

   // Out-of-frame indices always read as background, whatever the state.
   always_comb begin
      pix_d = DEFAULT_COLOUR;
      if ((pixel_index < 13'(PIX_TOTAL)) && (state_q == ST_SHOW)) begin
         pix_d = sel_pix_c;
`ifdef BORDER_EN
         if (on_border_c) pix_d = BORDER_COLOUR;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         pending_q   <= '0;
         cnt_q       <= '0;
         req_s1_q    <= '0;
         req_s2_q    <= '0;
         active_q    <= 1'b0;
         switching_q <= 1'b0;
         pix_q       <= DEFAULT_COLOUR;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         req_s1_q    <= req;
         req_s2_q    <= req_s1_q;
         active_q    <= (state_d == ST_SHOW);
         switching_q <= (state_d == ST_BLANK);
         pix_q       <= pix_d;
      end
   end

   assign pixel_data = pix_q;
   assign grant      = grant_q;
   assign active     = active_q;
   assign switching  = switching_q;

endmodule

// File: tb/tb_oled_source_arbiter.sv
// Scoreboard bench for oled_source_arbiter: stimulus pushes hand-computed expectations,
// a monitor pops and compares them one clock edge later.
module tb_oled_source_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_begin;
   logic [3:0]  req;
   logic [63:0] src_pixel;
   logic [12:0] pixel_index;
   logic [15:0] pixel_data;
   logic [3:0]  grant;
   logic        active;
   logic        switching;

   oled_source_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .frame_begin (frame_begin),
      .req         (req),
      .src_pixel   (src_pixel),
      .pixel_index (pixel_index),
      .pixel_data  (pixel_data),
      .grant       (grant),
      .active      (active),
      .switching   (switching)
   );

   always #5 clk = ~clk;

`ifdef BORDER_EN
   localparam logic [15:0] BRD2 = 16'h07E0;
`else
   localparam logic [15:0] BRD2 = 16'h1234;
`endif

   typedef struct {
      string       nm;
      logic [3:0]  g;
      logic        a;
      logic        s;
      logic [15:0] p;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic chk = 1'b0;
   int   total = 0;
   int   bad = 0;

   task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
      end
   endtask

   // Monitor: compare whenever the stimulus marks this edge's outputs as due.
   always @(posedge clk) begin
      #1;
      if (chk) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: check due with empty queue");
         end else begin
            mon_e = sb_q.pop_front();
            cmp(mon_e.nm, "grant", {12'h000, grant}, {12'h000, mon_e.g});
            cmp(mon_e.nm, "active", {15'h0000, active}, {15'h0000, mon_e.a});
            cmp(mon_e.nm, "switching", {15'h0000, switching}, {15'h0000, mon_e.s});
            cmp(mon_e.nm, "pixel", pixel_data, mon_e.p);
         end
      end
   end

   // Called just after a negedge; expectation applies after the next rising edge.
   task automatic expect_next(input string nm, input logic [3:0] g, input logic a,
                              input logic s, input logic [15:0] p);
      exp_t e;
      e.nm = nm; e.g = g; e.a = a; e.s = s; e.p = p;
      sb_q.push_back(e);
      chk = 1'b1;
      @(negedge clk);
      chk = 1'b0;
   endtask

   task automatic frame(input string nm, input logic [3:0] g, input logic a, input logic s);
      frame_begin = 1'b1;
      expect_next(nm, g, a, s, 16'h0000);
      frame_begin = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic pix(input string nm, input logic [12:0] idx, input logic [3:0] g,
                      input logic a, input logic s, input logic [15:0] p);
      pixel_index = idx;
      expect_next(nm, g, a, s, p);
      pixel_index = 13'd6200;
   endtask

   task automatic set_req(input logic [3:0] r);
      req = r;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      frame_begin = 1'b0;
      req         = 4'b0000;
      src_pixel   = {16'hAAAA, 16'h1234, 16'h5678, 16'h9ABC};
      pixel_index = 13'd6200;
      @(negedge clk);
      expect_next("reset", 4'b0000, 1'b0, 1'b0, 16'h0000);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // No requests: stay idle through several frames.
      for (int i = 0; i < 3; i++) frame("idle_frame", 4'b0000, 1'b0, 1'b0);
      pix("idle_pix", 13'd97, 4'b0000, 1'b0, 1'b0, 16'h0000);

      // Single request: two blank frames then ownership.
      set_req(4'b0100);
      frame("t2_blank1", 4'b0000, 1'b0, 1'b1);
      pix("t2_blank_pix", 13'd97, 4'b0000, 1'b0, 1'b1, 16'h0000);
      frame("t2_blank2", 4'b0000, 1'b0, 1'b1);
      frame("t2_show", 4'b0100, 1'b1, 1'b0);
      pix("t2_pix97", 13'd97, 4'b0100, 1'b1, 1'b0, 16'h1234);
      pix("t2_pix5000", 13'd5000, 4'b0100, 1'b1, 1'b0, 16'h1234);
      pix("t2_pix0", 13'd0, 4'b0100, 1'b1, 1'b0, BRD2);
      pix("t2_pix95", 13'd95, 4'b0100, 1'b1, 1'b0, BRD2);
      pix("t2_pix6048", 13'd6048, 4'b0100, 1'b1, 1'b0, BRD2);
      pix("t2_pix6143", 13'd6143, 4'b0100, 1'b1, 1'b0, BRD2);
      pix("t2_pix6144", 13'd6144, 4'b0100, 1'b1, 1'b0, 16'h0000);
      src_pixel[47:32] = 16'hF800;
      pix("t2_track", 13'd97, 4'b0100, 1'b1, 1'b0, 16'hF800);

      // Higher-priority request arrives: release, blank, hand over.
      set_req(4'b0110);
      frame("t3_release", 4'b0000, 1'b0, 1'b1);
      frame("t3_blank2", 4'b0000, 1'b0, 1'b1);
      frame("t3_show", 4'b0010, 1'b1, 1'b0);
      pix("t3_pix", 13'd200, 4'b0010, 1'b1, 1'b0, 16'h5678);

      // Glitch between frames must not disturb ownership.
      req = 4'b0111;
      repeat (10) @(negedge clk);
      pix("t4_mid_glitch", 13'd200, 4'b0010, 1'b1, 1'b0, 16'h5678);
      repeat (9) @(negedge clk);
      set_req(4'b0110);
      frame("t4_hold", 4'b0010, 1'b1, 1'b0);

      // Owner drops: back to idle.
      set_req(4'b0000);
      frame("show_to_idle", 4'b0000, 1'b0, 1'b0);

      // Reset in BLANK with cnt=1, then full blank sequence again.
      set_req(4'b0001);
      frame("t5_blank1", 4'b0000, 1'b0, 1'b1);
      frame("t5_blank2", 4'b0000, 1'b0, 1'b1);
      req = 4'b1000;
      reset = 1'b1;
      expect_next("t5_reset", 4'b0000, 1'b0, 1'b0, 16'h0000);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      frame("t5_after_b1", 4'b0000, 1'b0, 1'b1);
      frame("t5_after_b2", 4'b0000, 1'b0, 1'b1);
      frame("t5_show", 4'b1000, 1'b1, 1'b0);
      pix("t5_pix", 13'd300, 4'b1000, 1'b1, 1'b0, 16'hAAAA);

      // Winner changes mid-blank: blank count restarts.
      set_req(4'b1100);
      frame("rs_blank1", 4'b0000, 1'b0, 1'b1);
      frame("rs_blank2", 4'b0000, 1'b0, 1'b1);
      set_req(4'b1010);
      frame("rs_restart", 4'b0000, 1'b0, 1'b1);
      frame("rs_blank4", 4'b0000, 1'b0, 1'b1);
      frame("rs_show", 4'b0010, 1'b1, 1'b0);

      // Requests vanish during blanking: return to idle.
      set_req(4'b0001);
      frame("bi_blank", 4'b0000, 1'b0, 1'b1);
      set_req(4'b0000);
      frame("bi_idle", 4'b0000, 1'b0, 1'b0);

      // Request raised on the frame_begin cycle is not yet synchronised.
      req = 4'b0001;
      frame("sim_stay_idle", 4'b0000, 1'b0, 1'b0);
      frame("sim_next_blank", 4'b0000, 1'b0, 1'b1);

      repeat (3) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
